// File: rtl/hit_coincidence_latch_if.sv
`default_nettype none
// ============================================================================
//  Module      : hit_coincidence_latch_if
//  Description : Event readout bundle carrying one latched coincidence event
//                from the hit latch to downstream readout.
//                  evt_valid - event held and available (producer -> consumer)
//                  evt_ready - consumer accepts the event (consumer -> producer)
//                  evt_mask  - channels hit within the coincidence window
//                  evt_ts    - timestamp of the window-opening hit
//                Modports: master (producer side), slave (consumer side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface hit_coincidence_latch_if #(
  parameter int N_CH     = 8,
  parameter int TS_WIDTH = 16
);
  logic                evt_valid;
  logic                evt_ready;
  logic [N_CH-1:0]     evt_mask;
  logic [TS_WIDTH-1:0] evt_ts;

  modport master (output evt_valid, output evt_mask, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_mask, input evt_ts, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/hit_coincidence_latch.sv
`default_nettype none
// ============================================================================
//  Module      : hit_coincidence_latch
//  Description : Multi-channel hit latch. Synchronises asynchronous
//                discriminator inputs, detects rising edges, groups hits
//                inside a coincidence window into one timestamped event and
//                holds it until readout accepts it. Hits arriving while an
//                event is held are counted as missed (saturating).
//  Ports       : clk_copy   - sole clock, rising edge
//                rst_n      - asynchronous active-low reset
//                s          - asynchronous hit inputs, one per channel
//                clear      - synchronous soft clear (highest priority)
//                evt        - event handshake bundle (master side)
//                missed_cnt - saturating count of cycles with dropped hits
//                armed      - high while waiting for a window-opening hit
//  Revision    : 1.0 - initial release
// ============================================================================
module hit_coincidence_latch #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = 4,
  parameter int TS_WIDTH    = 16,
  parameter int MISS_WIDTH  = 8
) (
  input  logic                   clk_copy,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        s,
  input  logic                   clear,
  hit_coincidence_latch_if.master evt,
  output logic [MISS_WIDTH-1:0]  missed_cnt,
  output logic                   armed
);

  // Window counter only needs to hold WINDOW-1 down to 1.
  localparam int              WCW      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WCW-1:0]  W_INIT   = WCW'(WINDOW - 1);
  localparam logic [WCW-1:0]  W_LAST   = WCW'(1);
  localparam logic [MISS_WIDTH-1:0] MISS_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t                             state;
  logic [SYNC_STAGES-1:0][N_CH-1:0]   sync_q;
  logic [N_CH-1:0]                    sy_d;
  logic [N_CH-1:0]                    hit;
  logic [TS_WIDTH-1:0]                ts_cnt;
  logic [WCW-1:0]                     wcnt;

  // Synchroniser chain plus one extra flop for edge detection. Soft clear
  // deliberately leaves these alone so a level already high stays quiet.
  always_ff @(posedge clk_copy or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sy_d   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], s};
      sy_d   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign hit = sync_q[SYNC_STAGES-1] & ~sy_d;

  // Free-running timestamp; only a hard reset restarts it.
  always_ff @(posedge clk_copy or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_copy or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      evt.evt_valid <= 1'b0;
      evt.evt_mask  <= '0;
      evt.evt_ts    <= '0;
      wcnt          <= '0;
      missed_cnt    <= '0;
      armed         <= 1'b1;
    end else if (clear) begin
      state         <= ST_IDLE;
      evt.evt_valid <= 1'b0;
      evt.evt_mask  <= '0;
      evt.evt_ts    <= '0;
      wcnt          <= '0;
      missed_cnt    <= '0;
      armed         <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|hit) begin
            evt.evt_mask <= hit;
            evt.evt_ts   <= ts_cnt;
            wcnt         <= W_INIT;
            armed        <= 1'b0;
            // A one-cycle window closes in the opening cycle itself.
            if (WINDOW > 1) begin
              state <= ST_WINDOW;
            end else begin
              state         <= ST_HOLD;
              evt.evt_valid <= 1'b1;
            end
          end
        end

        ST_WINDOW: begin
          evt.evt_mask <= evt.evt_mask | hit;
          if (wcnt == W_LAST) begin
            state         <= ST_HOLD;
            evt.evt_valid <= 1'b1;
          end else begin
            wcnt <= wcnt - W_LAST;
          end
        end

        ST_HOLD: begin
          // Hits in the handshake cycle still count as missed.
          if ((|hit) && (missed_cnt != MISS_MAX)) begin
            missed_cnt <= missed_cnt + MISS_WIDTH'(1);
          end
          if (evt.evt_ready) begin
            state         <= ST_IDLE;
            evt.evt_valid <= 1'b0;
            evt.evt_mask  <= '0;
            armed         <= 1'b1;
          end
        end

        default: begin
          state         <= ST_IDLE;
          evt.evt_valid <= 1'b0;
          armed         <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/hit_coincidence_latch.md
Name: hit_coincidence_latch

Overview:
- Parametrised multi-channel hit latch for the scintillator chamber front end.
- Synchronises N_CH asynchronous discriminator inputs into the clk_copy domain and detects rising edges.
- Groups hits that fall within a programmable coincidence window into one event, stamped with a free-running timestamp.
- Holds the event until downstream readout accepts it via a valid/ready handshake, then re-arms. Hits arriving while an event is held are counted as missed.

Parameters:
- N_CH, 8, number of input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- WINDOW, 4, coincidence window length in clk_copy cycles (>=1).
- TS_WIDTH, 16, timestamp counter width.
- MISS_WIDTH, 8, missed-hit counter width.

Ports:
- clk_copy, input, 1: sole clock; all state is updated on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- s, input, N_CH: asynchronous hit inputs, one per channel.
- clear, input, 1: synchronous soft clear.
- evt_ready, input, 1: downstream accepts the event.
- evt_valid, output, 1: event held and available.
- evt_mask, output, N_CH: channels hit within the window.
- evt_ts, output, TS_WIDTH: timestamp of the window-opening hit.
- missed_cnt, output, MISS_WIDTH: saturating count of cycles with hits dropped while in HOLD.
- armed, output, 1: high in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All synchroniser flops, edge flops, evt_mask, evt_ts, timestamp counter, window counter and missed_cnt go to 0.
  - evt_valid=0, state=IDLE, armed=1.
- Synchroniser: s[i] passes through SYNC_STAGES flops to give sy[i]. One further flop holds sy_d[i].
- Hit pulse: hit[i] = sy[i] & ~sy_d[i], one cycle per rising edge. A level held high produces a single pulse.
- Latency: s rising edge to hit pulse is SYNC_STAGES cycles (±1 for input phase).
- Timestamp counter: free-running, +1 every cycle, wraps 2^TS_WIDTH-1 -> 0. Cleared only by rst_n, not by clear.
- IDLE:
  - If hit != 0: evt_mask <= hit, evt_ts <= current counter value, wcnt <= WINDOW-1.
  - Next state is WINDOW if WINDOW>1, otherwise HOLD.
- WINDOW:
  - evt_mask <= evt_mask | hit each cycle.
  - If wcnt==1 go to HOLD (hits in that cycle are still ORed in); else wcnt decrements.
  - The window covers exactly WINDOW cycles including the opening cycle.
- HOLD:
  - evt_valid=1; evt_mask and evt_ts are stable.
  - Any cycle with hit != 0 increments missed_cnt, saturating at all-ones, no wrap.
  - When evt_valid & evt_ready: next cycle evt_valid=0, evt_mask=0, state=IDLE.
  - Hits in the handshake cycle count as missed. Hits in the cycle after return to IDLE open a new window.
- evt_ready outside HOLD is ignored.
- clear (any state):
  - Highest priority, including over a simultaneous handshake or hit.
  - Next cycle: state=IDLE, evt_valid=0, evt_mask=0, evt_ts=0, missed_cnt=0.
  - Synchroniser and edge flops are not cleared, so a level already high does not re-trigger.
- rst_n asserted mid-window or mid-hold: immediate return to reset values; the pending event is lost.
- Simultaneous pulses on several channels in one cycle: all are captured in the same mask.
- Outputs are registered; no combinational path from s or evt_ready to any output.

Test Plan:
- N_CH=8, WINDOW=4: pulse s[3] at T, s[5] at T+2 cycles, s[0] at T+6 -> one event with evt_mask=0x28, evt_ts equal to the counter value at s[3]'s hit cycle. s[0] is missed (missed_cnt=1) if it arrives in HOLD; otherwise it opens a new event with mask 0x01.
- s=0xFF driven high together and held 20 cycles, evt_ready=1 -> exactly one event, mask 0xFF, evt_valid high for 1 cycle, missed_cnt=0, no re-trigger while the level is held.
- evt_ready=0 and 300 hit-cycles during HOLD -> missed_cnt saturates at 255. Then clear -> missed_cnt=0, evt_valid=0, armed=1.
- WINDOW=1: single pulse on s[7] -> HOLD entered the cycle after the hit, evt_mask=0x80.
- Timestamp wrap with TS_WIDTH=4: hits 16 cycles apart, each acknowledged -> identical evt_ts values.
- rst_n pulsed low during WINDOW with mask 0x0C -> all outputs 0, armed=1, and the next hit produces a fresh event.
